// File: rtl/note_video_pkg.sv
// note_video_pkg: shared channel state, default screen geometry and note-to-Y mapping.
package note_video_pkg;

    typedef enum logic {IDLE, SCROLL} ch_state_e;

    localparam int Y_BASE  = 45;
    localparam int Y_STEP  = 5;
    localparam int X_START = 600;
    localparam int X_STEP  = 2;
    localparam int X_END   = 40;

    function automatic int note_y(input int idx, input int base = Y_BASE, input int step = Y_STEP);
        return base + step * idx;
    endfunction

endpackage

// File: rtl/onehot_note_decoder.sv
// onehot_note_decoder: classifies a note code as rest, one-hot or invalid and yields its bit index.
module onehot_note_decoder #(
    parameter int NOTE_W = 8,
    localparam int IW = (NOTE_W > 1) ? $clog2(NOTE_W) : 1
) (
    input  logic [NOTE_W-1:0] code,
    output logic              is_zero,
    output logic              is_onehot,
    output logic [IW-1:0]     idx
);

    assign is_zero   = ~|code;
    assign is_onehot = !is_zero && ((code & (code - 1'b1)) == '0);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NOTE_W; i++)
            if (code[i]) idx = IW'(i);
    end

endmodule

// File: rtl/note_lane_tracker.sv
// note_lane_tracker: per-channel note handshake, one-hot to Y decode and per-frame X scrolling.
module note_lane_tracker
    import note_video_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int NOTE_W  = 8,
    parameter int POS_W   = 10,
    parameter int Y_BASE  = note_video_pkg::Y_BASE,
    parameter int Y_STEP  = note_video_pkg::Y_STEP,
    parameter int X_START = note_video_pkg::X_START,
    parameter int X_STEP  = note_video_pkg::X_STEP,
    parameter int X_END   = note_video_pkg::X_END
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    leyendo,
    input  logic                    frame_tick,
    input  logic [NUM_CH-1:0]       note_valid,
    input  logic [NUM_CH*NOTE_W-1:0] nota,
    output logic [NUM_CH-1:0]       note_ready,
    output logic [NUM_CH*POS_W-1:0] pos_y,
    output logic [NUM_CH*POS_W-1:0] pos_x,
    output logic [NUM_CH-1:0]       active,
    output logic [NUM_CH-1:0]       err_invalid
);

    localparam int IW = (NOTE_W > 1) ? $clog2(NOTE_W) : 1;
    // Comparing against END+STEP before subtracting keeps X from ever wrapping.
    localparam logic [POS_W-1:0] X_LIM = POS_W'(X_END + X_STEP);
    localparam logic [POS_W-1:0] X_DEC = POS_W'(X_STEP);
    localparam logic [POS_W-1:0] X_LD  = POS_W'(X_START);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [NOTE_W-1:0] code;
        logic              is_zero, is_onehot;
        logic [IW-1:0]     idx;
        ch_state_e         state_q, state_d;
        logic [POS_W-1:0]  y_q, y_d, x_q, x_d;
        logic              err_q, err_d;
        logic              ready;

        assign code  = nota[c*NOTE_W +: NOTE_W];
        assign ready = reset && leyendo && (state_q == IDLE);

        onehot_note_decoder #(.NOTE_W(NOTE_W)) u_dec (
            .code      (code),
            .is_zero   (is_zero),
            .is_onehot (is_onehot),
            .idx       (idx)
        );

        always_comb begin
            state_d = state_q;
            y_d     = y_q;
            x_d     = x_q;
            err_d   = 1'b0;
            if (!leyendo) begin
                state_d = IDLE;
            end else if (ready && note_valid[c]) begin
                if (is_onehot) begin
                    y_d     = POS_W'(note_y(int'(idx), Y_BASE, Y_STEP));
                    x_d     = X_LD;
                    state_d = SCROLL;
                end else begin
                    err_d = !is_zero;
                end
            end else if (state_q == SCROLL && frame_tick) begin
                if (x_q >= X_LIM) x_d = x_q - X_DEC;
                else state_d = IDLE;
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                y_q     <= '0;
                x_q     <= '0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                y_q     <= y_d;
                x_q     <= x_d;
                err_q   <= err_d;
            end
        end

        assign note_ready[c]             = ready;
        assign active[c]                 = (state_q == SCROLL);
        assign err_invalid[c]            = err_q;
        assign pos_y[c*POS_W +: POS_W]   = y_q;
        assign pos_x[c*POS_W +: POS_W]   = x_q;
    end

endmodule

// File: tb/tb_note_lane_tracker.sv
// tb_note_lane_tracker: directed and randomized checks of note_lane_tracker against a behavioural model.
module tb_note_lane_tracker;

    localparam int NC = 2;
    localparam int NW = 8;
    localparam int PW = 10;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            leyendo = 1'b0;
    logic            frame_tick = 1'b0;
    logic [NC-1:0]   note_valid = '0;
    logic [NC*NW-1:0] nota = '0;
    logic [NC-1:0]   note_ready, active, err_invalid;
    logic [NC*PW-1:0] pos_y, pos_x;

    int n_vec = 0;
    int n_bad = 0;

    bit m_act[NC];
    bit m_err[NC];
    int m_x[NC];
    int m_y[NC];

    note_lane_tracker dut (
        .clock       (clock),
        .reset       (reset),
        .leyendo     (leyendo),
        .frame_tick  (frame_tick),
        .note_valid  (note_valid),
        .nota        (nota),
        .note_ready  (note_ready),
        .pos_y       (pos_y),
        .pos_x       (pos_x),
        .active      (active),
        .err_invalid (err_invalid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int py(input int c);
        return int'(pos_y[c*PW +: PW]);
    endfunction

    function automatic int px(input int c);
        return int'(pos_x[c*PW +: PW]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_act[c] = 0; m_err[c] = 0; m_x[c] = 0; m_y[c] = 0;
        end
    endtask

    // Reference behaviour: Y from note index arithmetic, X scrolls in steps of 2 down to 40.
    task automatic model_update();
        if (!reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NC; c++) begin
            logic [NW-1:0] code;
            code = nota[c*NW +: NW];
            m_err[c] = 0;
            if (!leyendo) begin
                m_act[c] = 0;
            end else if (!m_act[c] && note_valid[c]) begin
                if ($countones(code) == 1) begin
                    for (int i = 0; i < NW; i++)
                        if (code[i]) m_y[c] = 45 + 5 * i;
                    m_x[c] = 600;
                    m_act[c] = 1;
                end else if (code != 0) begin
                    m_err[c] = 1;
                end
            end else if (m_act[c] && frame_tick) begin
                if (m_x[c] - 2 >= 40) m_x[c] = m_x[c] - 2;
                else m_act[c] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("ready%0d", c), int'(note_ready[c]), int'(reset && leyendo && !m_act[c]));
            chk($sformatf("active%0d", c), int'(active[c]), int'(m_act[c]));
            chk($sformatf("err%0d", c), int'(err_invalid[c]), int'(m_err[c]));
            chk($sformatf("pos_y%0d", c), py(c), m_y[c]);
            chk($sformatf("pos_x%0d", c), px(c), m_x[c]);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        @(negedge clock);
        check_all();
    endtask

    task automatic offer(input int c, input bit v, input logic [NW-1:0] code);
        note_valid[c] = v;
        nota[c*NW +: NW] = code;
    endtask

    initial begin
        model_reset();
        step();
        step();
        chk("rst_y0", py(0), 0);
        chk("rst_ready0", int'(note_ready[0]), 0);
        reset = 1'b1;
        leyendo = 1'b1;

        // highest note on ch0
        offer(0, 1, 8'h80);
        step();
        offer(0, 0, 8'h00);
        chk("t1_y0", py(0), 80);
        chk("t1_x0", px(0), 600);
        chk("t1_act0", int'(active[0]), 1);
        chk("t1_ready0", int'(note_ready[0]), 0);
        chk("t1_y1", py(1), 0);

        // abort, then full scroll of note 0
        leyendo = 1'b0;
        step();
        chk("abort_act0", int'(active[0]), 0);
        chk("abort_y0", py(0), 80);
        leyendo = 1'b1;
        offer(0, 1, 8'h01);
        step();
        offer(0, 0, 8'h00);
        chk("t2_y0", py(0), 45);
        for (int t = 0; t < 280; t++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
        chk("t2_x0_end", px(0), 40);
        chk("t2_act0_end", int'(active[0]), 1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("t2_act0_term", int'(active[0]), 0);
        chk("t2_x0_term", px(0), 40);
        chk("t2_ready0_term", int'(note_ready[0]), 1);

        // invalid then rest code on ch1
        offer(1, 1, 8'h24);
        step();
        offer(1, 0, 8'h00);
        chk("t3_err1", int'(err_invalid[1]), 1);
        chk("t3_act1", int'(active[1]), 0);
        chk("t3_y1", py(1), 0);
        step();
        chk("t3_err1_clr", int'(err_invalid[1]), 0);
        offer(1, 1, 8'h00);
        step();
        offer(1, 0, 8'h00);
        chk("t3_rest_err1", int'(err_invalid[1]), 0);
        chk("t3_rest_act1", int'(active[1]), 0);

        // note held while scrolling, accepted only once the lane frees up
        offer(0, 1, 8'h01);
        step();
        offer(0, 1, 8'h10);
        frame_tick = 1'b1;
        for (int t = 0; t < 281; t++) step();
        chk("t4_act0_free", int'(active[0]), 0);
        chk("t4_ready0_free", int'(note_ready[0]), 1);
        step();
        offer(0, 0, 8'h00);
        frame_tick = 1'b0;
        chk("t4_y0", py(0), 65);
        chk("t4_x0", px(0), 600);

        // simultaneous accepts on both lanes with a coincident tick
        leyendo = 1'b0;
        step();
        leyendo = 1'b1;
        offer(0, 1, 8'h40);
        offer(1, 1, 8'h02);
        frame_tick = 1'b1;
        step();
        offer(0, 0, 8'h00);
        offer(1, 0, 8'h00);
        chk("t5_y0", py(0), 75);
        chk("t5_y1", py(1), 50);
        chk("t5_x0", px(0), 600);
        chk("t5_x1", px(1), 600);
        step();
        frame_tick = 1'b0;
        chk("t5_x0_dec", px(0), 598);
        chk("t5_x1_dec", px(1), 598);

        // play stop mid-scroll, then asynchronous reset
        leyendo = 1'b0;
        step();
        chk("t6_act0", int'(active[0]), 0);
        chk("t6_x0_hold", px(0), 598);
        chk("t6_y1_hold", py(1), 50);
        leyendo = 1'b1;
        offer(0, 1, 8'h08);
        step();
        offer(0, 0, 8'h00);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_y0", py(0), 0);
        chk("t6_async_x1", px(1), 0);
        chk("t6_async_act0", int'(active[0]), 0);
        chk("t6_async_ready", int'(note_ready), 0);
        model_reset();
        @(negedge clock);
        check_all();
        reset = 1'b1;

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            leyendo    = ($urandom_range(0, 99) < 97);
            frame_tick = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < NC; c++) begin
                int unsigned r;
                logic [NW-1:0] code;
                r = $urandom_range(0, 3);
                code = (r == 0) ? 8'h00 : (r == 3) ? NW'($urandom) : NW'(1 << $urandom_range(0, NW - 1));
                offer(c, $urandom_range(0, 1) == 1, code);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
